// File: rtl/i2s_frame_packer.sv
// i2s_frame_packer: packs per-frame PCM samples across NUM_CH channels into a byte FIFO, one byte per SPI load.
// Build option SYNC_HEADER_EN prefixes each committed frame with 8'hA5 and an 8-bit frame sequence number.
//
// asm state | meaning
// COLLECT   | accepting samples, exp_ch is the next channel wanted
// COMMIT    | frame just completed: hand it to the writer or drop it
// wr state  | meaning
// W_IDLE    | no frame in flight
// W_WRITE   | one byte per cycle from wbuf into the FIFO, wr_cnt counts down to 0
module i2s_frame_packer #(
  parameter int NUM_CH     = 2,
  parameter int SAMPLE_W   = 24,
  parameter int OUT_BYTES  = 3,
  parameter int FIFO_DEPTH = 131072,
  parameter int CNT_W      = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pcm_valid,
  input  logic [CH_W-1:0]     pcm_ch,
  input  logic [SAMPLE_W-1:0] pcm_data,
  input  logic                spi_busy,
  output logic [7:0]          spi_tx_data,
  output logic                spi_tx_valid,
  output logic [LVL_W-1:0]    fifo_level,
  output logic                fifo_empty,
  output logic                fifo_full,
  output logic [CNT_W-1:0]    drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SB = 8 * OUT_BYTES;
`ifdef SYNC_HEADER_EN
  localparam int HB = 2;
`else
  localparam int HB = 0;
`endif
  localparam int FB   = NUM_CH * OUT_BYTES + HB;
  localparam int FW   = 8 * FB;
  localparam int WC_W = $clog2(FB + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic {COLLECT, COMMIT} asm_state_t;
  typedef enum logic {W_IDLE, W_WRITE} wr_state_t;

  asm_state_t asm_state, asm_next;
  wr_state_t  wr_state, wr_next;

  logic [CH_W-1:0]   exp_ch, exp_next;
  logic              stage_we;
  logic [CH_W-1:0]   stage_idx;
  logic [SB-1:0]     pcm_fmt;
  logic [SB-1:0]     stage [NUM_CH];
  logic [NUM_CH*SB-1:0] frame_bits;
  logic [FW-1:0]     frame_load, wbuf;
  logic [WC_W-1:0]   wr_cnt;
  logic              commit_ok, wr_en;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [7:0]        rd_data;
  logic              rd_en, rd_vld;
  logic              busy_s1, busy_s2, busy_s3, busy_edge;

  // Keep the top bits, MSB-aligned; narrower samples get zero LSBs
  generate
    if (SAMPLE_W >= SB) begin : g_trunc
      assign pcm_fmt = pcm_data[SAMPLE_W-1 -: SB];
    end else begin : g_pad
      assign pcm_fmt = {pcm_data, {(SB - SAMPLE_W){1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_state <= COLLECT;
      exp_ch    <= '0;
    end else begin
      asm_state <= asm_next;
      exp_ch    <= exp_next;
    end
  end

  // COMMIT still accepts a sample: the copy into wbuf sees the pre-edge stage
  always_comb begin
    asm_next  = COLLECT;
    exp_next  = exp_ch;
    stage_we  = 1'b0;
    stage_idx = exp_ch;
    if (pcm_valid) begin
      if (pcm_ch == exp_ch) begin
        stage_we = 1'b1;
        if (exp_ch == LAST_CH) begin
          exp_next = '0;
          asm_next = COMMIT;
        end else begin
          exp_next = exp_ch + 1'b1;
        end
      end else if (pcm_ch == '0) begin
        stage_we  = 1'b1;
        stage_idx = '0;
        exp_next  = CH_W'(1);
      end else begin
        exp_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (stage_we) stage[stage_idx] <= pcm_fmt;
  end

  always_comb begin
    frame_bits = '0;
    for (int c = 0; c < NUM_CH; c++) frame_bits[c*SB +: SB] = stage[c];
  end

  assign commit_ok = (asm_state == COMMIT) && (wr_state == W_IDLE) &&
                     (fifo_level <= LVL_W'(FIFO_DEPTH - FB));

`ifdef SYNC_HEADER_EN
  logic [7:0] seq_num;
  always_ff @(posedge clk) begin
    if (!rst_n)                   seq_num <= '0;
    else if (asm_state == COMMIT) seq_num <= seq_num + 1'b1;
  end
  assign frame_load = {frame_bits, seq_num, 8'hA5};
`else
  assign frame_load = frame_bits;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (asm_state == COMMIT && !commit_ok && drop_count != {CNT_W{1'b1}}) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state <= W_IDLE;
      wr_cnt   <= '0;
      wbuf     <= '0;
    end else begin
      wr_state <= wr_next;
      if (commit_ok) begin
        wbuf   <= frame_load;
        wr_cnt <= WC_W'(FB - 1);
      end else if (wr_state == W_WRITE) begin
        wbuf   <= wbuf >> 8;
        wr_cnt <= wr_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (commit_ok) wr_next = W_WRITE;
      W_WRITE: if (wr_cnt == '0) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  assign wr_en = (wr_state == W_WRITE);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wbuf[7:0];
    if (rd_en) rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign busy_edge  = busy_s2 & ~busy_s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_s1      <= 1'b0;
      busy_s2      <= 1'b0;
      busy_s3      <= 1'b0;
      rd_en        <= 1'b0;
      rd_vld       <= 1'b0;
      spi_tx_data  <= 8'h00;
      spi_tx_valid <= 1'b0;
    end else begin
      busy_s1      <= spi_busy;
      busy_s2      <= busy_s1;
      busy_s3      <= busy_s2;
      rd_en        <= busy_edge & ~fifo_empty;
      rd_vld       <= rd_en;
      spi_tx_valid <= 1'b0;
      if (busy_edge && fifo_empty) begin
        spi_tx_data  <= 8'h00;
        spi_tx_valid <= 1'b1;
      end else if (rd_vld) begin
        spi_tx_data  <= rd_data;
        spi_tx_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_packer.sv
// Bench for i2s_frame_packer: two instances (24b/3-byte exact, 12b/2-byte padded in an 8-byte FIFO)
// checked against a frame-level reference model; SYNC_HEADER_EN selects header mode in both.
module tb_i2s_frame_packer;

  localparam int NCH = 2;
`ifdef SYNC_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  int sw  [2] = '{24, 12};
  int ob  [2] = '{3, 2};
  int dep [2] = '{64, 8};
  int fb  [2] = '{NCH*3 + HDR, NCH*2 + HDR};

  logic clk = 1'b0;
  logic rst_n;
  logic pcm_valid [2];
  logic pcm_ch    [2];
  logic [31:0] pcm_data [2];
  logic spi_busy  [2];
  logic [7:0] tx_data [2];
  logic tx_valid [2];
  logic empty [2];
  logic full  [2];
  logic [7:0] drop [2];
  logic [6:0] level_a;
  logic [3:0] level_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_exp [2];
  int m_drop [2];
  int m_seq [2];
  int m_last [2];
  int mhd [2];
  int mcnt [2];
  logic [31:0] m_stage [2][2];
  logic [7:0] mbuf [2][256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_frame_packer #(.NUM_CH(2), .SAMPLE_W(24), .OUT_BYTES(3), .FIFO_DEPTH(64), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .pcm_valid(pcm_valid[0]), .pcm_ch(pcm_ch[0]),
    .pcm_data(pcm_data[0][23:0]), .spi_busy(spi_busy[0]), .spi_tx_data(tx_data[0]),
    .spi_tx_valid(tx_valid[0]), .fifo_level(level_a), .fifo_empty(empty[0]),
    .fifo_full(full[0]), .drop_count(drop[0]));

  i2s_frame_packer #(.NUM_CH(2), .SAMPLE_W(12), .OUT_BYTES(2), .FIFO_DEPTH(8), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .pcm_valid(pcm_valid[1]), .pcm_ch(pcm_ch[1]),
    .pcm_data(pcm_data[1][11:0]), .spi_busy(spi_busy[1]), .spi_tx_data(tx_data[1]),
    .spi_tx_valid(tx_valid[1]), .fifo_level(level_b), .fifo_empty(empty[1]),
    .fifo_full(full[1]), .drop_count(drop[1]));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fmt(int d, logic [31:0] data);
    longint v;
    v = longint'(data) & ((longint'(1) << sw[d]) - 1);
    if (sw[d] >= 8*ob[d]) v = v >> (sw[d] - 8*ob[d]);
    else                  v = v << (8*ob[d] - sw[d]);
    return v[31:0];
  endfunction

  task automatic push(int d, logic [7:0] b);
    mbuf[d][(mhd[d] + mcnt[d]) % 256] = b;
    mcnt[d]++;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_exp[d] = 0; m_drop[d] = 0; m_seq[d] = 0; m_last[d] = -1000;
      mhd[d] = 0; mcnt[d] = 0;
    end
  endtask

  // q is the clock edge at which the frame's admission is decided
  task automatic complete(int d, int q);
    if (dep[d] - mcnt[d] >= fb[d] && q >= m_last[d] + fb[d] + 1) begin
      if (HDR != 0) begin
        push(d, 8'hA5);
        push(d, 8'(m_seq[d]));
      end
      for (int c = 0; c < NCH; c++)
        for (int b = 0; b < ob[d]; b++)
          push(d, 8'((m_stage[d][c] >> (8*b)) & 32'hFF));
      m_last[d] = q;
    end else if (m_drop[d] < 255) begin
      m_drop[d]++;
    end
    m_seq[d] = (m_seq[d] + 1) % 256;
  endtask

  task automatic model_sample(int d, int ch, logic [31:0] data, int q);
    if (ch == m_exp[d]) begin
      m_stage[d][ch] = fmt(d, data);
      if (ch == NCH - 1) begin
        m_exp[d] = 0;
        complete(d, q);
      end else begin
        m_exp[d] = ch + 1;
      end
    end else if (ch == 0) begin
      m_stage[d][0] = fmt(d, data);
      m_exp[d] = 1;
    end else begin
      m_exp[d] = 0;
    end
  endtask

  task automatic send(int d, int ch, logic [31:0] data);
    pcm_valid[d] = 1'b1;
    pcm_ch[d]    = ch[0];
    pcm_data[d]  = data;
    @(negedge clk);
    pcm_valid[d] = 1'b0;
    model_sample(d, ch, data, cyc + 1);
  endtask

  task automatic send_frame(int d, logic [31:0] s0, logic [31:0] s1);
    send(d, 0, s0);
    send(d, 1, s1);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_check(int d, string tag);
    logic [7:0] exp_b, got_b;
    int nv;
    if (mcnt[d] == 0) exp_b = 8'h00;
    else begin
      exp_b = mbuf[d][mhd[d]];
      mhd[d] = (mhd[d] + 1) % 256;
      mcnt[d]--;
    end
    nv = 0;
    got_b = 8'hxx;
    spi_busy[d] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 3) spi_busy[d] = 1'b0;
      if (tx_valid[d] === 1'b1) begin
        nv++;
        got_b = tx_data[d];
      end
    end
    chk({tag, "_valid_count"}, nv, 1);
    chk({tag, "_data"}, got_b, exp_b);
  endtask

  task automatic drain(int d, string tag);
    while (mcnt[d] > 0) read_check(d, tag);
    read_check(d, {tag, "_empty_read"});
  endtask

  task automatic status(int d, string tag);
    chk({tag, "_level"}, (d == 0) ? 32'(level_a) : 32'(level_b), mcnt[d]);
    chk({tag, "_empty"}, empty[d], mcnt[d] == 0);
    chk({tag, "_full"},  full[d],  mcnt[d] == dep[d]);
    chk({tag, "_drops"}, drop[d],  m_drop[d]);
  endtask

  task automatic reset_values(string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_level"}, (d == 0) ? 32'(level_a) : 32'(level_b), 0);
      chk({tag, "_empty"}, empty[d], 1);
      chk({tag, "_full"},  full[d], 0);
      chk({tag, "_drops"}, drop[d], 0);
      chk({tag, "_tx_data"}, tx_data[d], 0);
      chk({tag, "_tx_valid"}, tx_valid[d], 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      pcm_valid[d] = 1'b0; pcm_ch[d] = 1'b0; pcm_data[d] = '0; spi_busy[d] = 1'b0;
    end
    model_reset();
    idle(3);
    reset_values("reset");
    rst_n = 1'b1;
    idle(2);

    // basic frame and readout order, then one read past empty
    send_frame(0, 32'h123456, 32'hABCDEF);
    idle(fb[0] + 4);
    status(0, "basic");
    drain(0, "basic_rd");

    // channel resync: ch0, ch0, ch1 yields one frame from the second ch0
    send(0, 0, 32'h111111);
    send(0, 0, 32'h222222);
    send(0, 1, 32'h333333);
    idle(fb[0] + 4);
    status(0, "resync");
    drain(0, "resync_rd");

    // full FIFO on the 8-byte instance
    for (int f = 0; f < 3; f++) begin
      send_frame(1, $urandom, $urandom);
      idle(fb[1] + 4);
      status(1, "full");
    end
    drain(1, "full_rd");

    // random channel sequences and gaps, including back-to-back frames
    for (int i = 0; i < 60; i++) begin
      int ch;
      ch = ($urandom_range(0, 9) < 8) ? m_exp[0] : int'($urandom_range(0, 1));
      send(0, ch, $urandom);
      idle($urandom_range(0, 4));
    end
    idle(fb[0] + 4);
    status(0, "rand");
    drain(0, "rand_rd");
    status(0, "rand_drained");

    // drop counter saturation
    send_frame(1, $urandom, $urandom);
    idle(fb[1] + 4);
    for (int f = 0; f < 300; f++) send_frame(1, $urandom, $urandom);
    idle(fb[1] + 4);
    status(1, "sat");
    chk("sat_drop_255", drop[1], 255);
    drain(1, "sat_rd");

    // reset while the writer is mid-frame
    send_frame(0, $urandom, $urandom);
    idle(2);
    rst_n = 1'b0;
    idle(1);
    reset_values("midwrite_reset");
    rst_n = 1'b1;
    model_reset();
    idle(2);
    send_frame(0, $urandom, $urandom);
    idle(fb[0] + 4);
    status(0, "after_reset");
    drain(0, "after_reset_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_frame_packer.md
# i2s_frame_packer

Multi-channel successor to the single-channel capture-to-SPI path. It takes PCM samples from the I2S receiver, assembles them into per-frame groups across `NUM_CH` channels, and truncates or pads each sample to `OUT_BYTES`. Each frame is written atomically into the byte FIFO, or the whole frame is dropped and counted. On each SPI transaction start, one byte is fed from the FIFO to the SPI slave.

## Interface
Reset and clock: reset `rst_n`, synchronous, active-low; clock `clk`.

Parameters:
- `NUM_CH`, default 2: channels per frame, 1..8.
- `SAMPLE_W`, default 24: input sample width, 8..32.
- `OUT_BYTES`, default 3: bytes stored per sample, 1..4.
- `FIFO_DEPTH`, default 131072: FIFO depth in bytes, power of 2.
- `CNT_W`, default 8: width of `drop_count`.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous active-low reset
- `pcm_valid`  in  1  one-cycle strobe, sample present
- `pcm_ch`  in  `CH_W = max(1,$clog2(NUM_CH))`  channel index of the sample
- `pcm_data`  in  `SAMPLE_W`  two's-complement sample
- `spi_busy`  in  1  SPI slave busy, asynchronous, synchronised internally
- `spi_tx_data`  out  8  byte for the next SPI transfer
- `spi_tx_valid`  out  1  one-cycle load strobe to the SPI slave
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  bytes currently stored
- `fifo_empty`  out  1  `fifo_level == 0`
- `fifo_full`  out  1  `fifo_level == FIFO_DEPTH`
- `drop_count`  out  `CNT_W`  dropped frames, saturating

## Operation
**Sample formatting**
- The top `min(SAMPLE_W, 8*OUT_BYTES)` bits are kept, MSB-aligned.
- If `8*OUT_BYTES > SAMPLE_W`, the LSBs are zero-padded.

**Assembler** (states `COLLECT`, `COMMIT`)
- An expected-channel counter starts at 0.
- On `pcm_valid` with `pcm_ch == expected`: store the sample in stage[`pcm_ch`] and increment the counter.
- On `pcm_valid` with `pcm_ch != expected`: discard the partial frame.
  - If `pcm_ch == 0`, restart the frame with this sample.
  - Otherwise set expected to 0.
  - A discarded partial frame is not counted in `drop_count`.
- When the sample for `NUM_CH-1` is stored, the frame is complete.
  - Let `FB = NUM_CH*OUT_BYTES` (+2 with header).
  - If `FIFO_DEPTH - fifo_level >= FB` and the writer is idle, copy the stage into the write buffer and start the writer.
  - Otherwise drop the frame and increment `drop_count`, saturating at `2^CNT_W-1`.
  - Either way, return to `COLLECT` with expected = 0.
  - The stage is free the cycle after completion, so the next sample is accepted immediately.

**Writer** (states `IDLE`, `WRITE`)
- Emits one byte per cycle, `FB` consecutive cycles, with no gaps.
- Order: channel 0 first; within a sample, LSB byte first.

**Reader**
- `busy` passes through a 2-flop synchroniser, then a rising-edge detector.
- On an edge with the FIFO empty: drive `spi_tx_data = 8'h00` with `spi_tx_valid`.
- On an edge with the FIFO non-empty: pop one byte and present it.

**Level counter**
- Increments per write and decrements per read.
- A simultaneous write and read leaves it unchanged.
- It never wraps, because admission checks free space.

## Timing
- Reset values:
  - `spi_tx_data = 0`, `spi_tx_valid = 0`.
  - `fifo_level = 0`, `fifo_empty = 1`, `fifo_full = 0`.
  - `drop_count = 0`.
  - Assembler in `COLLECT` with expected = 0; writer `IDLE`; FIFO pointers cleared.
- Reset mid-frame or mid-write discards all staged and buffered data.
- Commit decision: the cycle after the last sample's `pcm_valid`.
  - First FIFO write: commit +1.
  - Last FIFO write: commit +`FB`.
- Reader, from edge pulse E:
  - Empty: `spi_tx_valid` at E+1.
  - Non-empty: `rd_en` at E+1, FIFO data at E+2, `spi_tx_data`/`spi_tx_valid` registered at E+3.
  - `spi_tx_data` holds its value until the next load.
- Empty/non-empty is sampled at E.
  - A byte written at E is not seen until the next edge.
- Edges closer than 4 cycles are not supported; the SPI byte period guarantees the spacing.

## Configuration
- `SYNC_HEADER_EN` defined:
  - Each committed frame is prefixed by `8'hA5`, then an 8-bit sequence number.
  - The sequence number increments on every completed frame, committed or dropped, and wraps 255→0, so host-side gaps reveal drops.
  - `FB = NUM_CH*OUT_BYTES + 2`.
- `SYNC_HEADER_EN` undefined:
  - No header and no sequence counter.
  - `FB = NUM_CH*OUT_BYTES`.

## Test plan
- Samples and readout: `NUM_CH=2`, `OUT_BYTES=3`, no header. Send ch0 `24'h123456`, then ch1 `24'hABCDEF`.
  - → FIFO holds 56 34 12 EF CD AB.
  - Six SPI busy edges read those bytes in order.
  - The seventh edge returns 00.
- Channel resync: send ch0, ch0, ch1.
  - → Exactly one frame is written, made from the second ch0 and the ch1.
  - `drop_count` stays 0.
- Full FIFO: `FIFO_DEPTH=8`, `OUT_BYTES=2`, three complete frames, no reads.
  - → `fifo_level = 8` and `fifo_full = 1` after two frames.
  - The third frame is dropped and `drop_count = 1`.
  - No partial bytes are written.
- Drop counter saturation: 300 drops with `CNT_W=8`.
  - → `drop_count` holds at 255.
- Header mode: `SYNC_HEADER_EN` defined, 2 frames, with the second dropped via a full FIFO, then a third frame.
  - → Stream reads A5 00 … A5 02 …
- Reset mid-write: assert `rst_n = 0` during the `WRITE` state.
  - → Next cycle `fifo_level = 0`, `fifo_empty = 1`, and all outputs are at their reset values.
  - The next frame is stored cleanly.
